// File: rtl/disp_pkg.sv
// Shared page encoding, blank codes and helpers for the display page scheduler.
package disp_pkg;

   typedef enum logic [1:0] {
      PG_TIME = 2'd0,
      PG_DATE = 2'd1,
      PG_TEMP = 2'd2,
      PG_MSG  = 2'd3
   } page_e;

   // Nibble code that turns every segment of a shuma digit off
   localparam logic [3:0]  BLANK      = 4'hF;
   localparam logic [31:0] BLANK_WORD = {8{BLANK}};

   // Counter width for a modulus-n counter; never below one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] blink_apply(input logic [31:0] dat, input logic [7:0] mask);
      logic [31:0] out;
      out = dat;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) out[4*i +: 4] = BLANK;
      end
      return out;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: o_tick pulses for one cycle every CLK_HZ enabled cycles.
// Synchronous clear restarts the period; disabling freezes the count.
module tick_gen
   import disp_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int            W    = cnt_w(CLK_HZ);
   localparam logic [W-1:0]  TERM = W'(CLK_HZ - 1);

   logic [W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/disp_sched.sv
// Page scheduler feeding shuma.din: rotates TIME/DATE/TEMP, takes one-shot message overrides.
// dout and page are registered from the next state (1-cycle latency); msg_req is acked one cycle later.
module disp_sched
   import disp_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int PAGE_SEC   = 5,
   parameter int MSG_SEC    = 2,
   parameter int BLINK_HALF = 12_500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] time_dat,
   input  logic [31:0] date_dat,
   input  logic [31:0] temp_dat,
   input  logic        temp_vld,
   input  logic        msg_req,
   input  logic [31:0] msg_dat,
   output logic        msg_ack,
   input  logic [7:0]  blink_mask,
   input  logic        hold,
   output logic [31:0] dout,
   output logic [1:0]  page
);

   localparam int           DW      = cnt_w((PAGE_SEC > MSG_SEC) ? PAGE_SEC : MSG_SEC);
   localparam int           BW      = cnt_w(BLINK_HALF);
   localparam logic [DW-1:0] PG_TERM  = DW'(PAGE_SEC - 1);
   localparam logic [DW-1:0] MSG_TERM = DW'(MSG_SEC - 1);
   localparam logic [BW-1:0] BL_TERM  = BW'(BLINK_HALF - 1);

   page_e         r_state;
   page_e         r_ret;
   logic          r_ack;
   logic [31:0]   r_msg;
   logic [31:0]   r_dout;
   logic [DW-1:0] r_dwell;
   logic [BW-1:0] r_bcnt;
   logic          r_boff;

   page_e         w_state_nx;
   logic          w_tick;
   logic          w_clr;
   logic          w_en;
   logic          w_expire;
   logic          w_req_acc;
   logic [DW-1:0] w_dwell_term;
   logic [31:0]   w_msg_nx;
   logic [31:0]   w_dout_nx;

   // Hold freezes rotation only; a message always runs out its own dwell
   assign w_en         = !hold || (r_state == PG_MSG);
   assign w_clr        = (w_state_nx != r_state);
   assign w_dwell_term = (r_state == PG_MSG) ? MSG_TERM : PG_TERM;
   assign w_expire     = w_tick && (r_dwell == w_dwell_term);
   assign w_req_acc    = msg_req && !r_ack && (r_state != PG_MSG);
   assign w_msg_nx     = r_ack ? msg_dat : r_msg;

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .o_tick (w_tick)
   );

   always_comb begin
      w_state_nx = r_state;
      if (r_ack) begin
         w_state_nx = PG_MSG;
      end else begin
         case (r_state)
            PG_TIME: if (w_expire && !w_req_acc) w_state_nx = PG_DATE;
            PG_DATE: if (w_expire && !w_req_acc) w_state_nx = temp_vld ? PG_TEMP : PG_TIME;
            // Invalid temperature is never shown, even under hold
            PG_TEMP: if (!temp_vld || (w_expire && !w_req_acc)) w_state_nx = PG_TIME;
            PG_MSG: begin
               if (w_expire) begin
                  w_state_nx = ((r_ret == PG_TEMP) && !temp_vld) ? PG_TIME : r_ret;
               end
            end
            default: w_state_nx = PG_TIME;
         endcase
      end
   end

   always_comb begin
      w_dout_nx = BLANK_WORD;
      case (w_state_nx)
         PG_TIME: w_dout_nx = r_boff ? blink_apply(time_dat, blink_mask) : time_dat;
         PG_DATE: w_dout_nx = date_dat;
         PG_TEMP: w_dout_nx = temp_dat;
         PG_MSG:  w_dout_nx = w_msg_nx;
         default: w_dout_nx = BLANK_WORD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PG_TIME;
         r_ret   <= PG_TIME;
         r_ack   <= 1'b0;
         r_msg   <= BLANK_WORD;
         r_dout  <= BLANK_WORD;
      end else begin
         r_state <= w_state_nx;
         r_ack   <= w_req_acc;
         r_dout  <= w_dout_nx;
         if (r_ack) begin
            r_msg <= msg_dat;
            r_ret <= r_state;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell <= '0;
      end else if (w_clr) begin
         r_dwell <= '0;
      end else if (w_tick) begin
         r_dwell <= w_expire ? '0 : r_dwell + 1'b1;
      end
   end

   // Free-running blink phase; deliberately not tied to page changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt <= '0;
         r_boff <= 1'b0;
      end else if (r_bcnt == BL_TERM) begin
         r_bcnt <= '0;
         r_boff <= ~r_boff;
      end else begin
         r_bcnt <= r_bcnt + 1'b1;
      end
   end

   assign dout    = r_dout;
   assign page    = r_state;
   assign msg_ack = r_ack;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with a 10-cycle second, 2 s pages, 1 s messages, 3-cycle blink half.
module tb_disp_sched;

   logic        clk;
   logic        rst_n;
   logic [31:0] time_dat;
   logic [31:0] date_dat;
   logic [31:0] temp_dat;
   logic        temp_vld;
   logic        msg_req;
   logic [31:0] msg_dat;
   logic        msg_ack;
   logic [7:0]  blink_mask;
   logic        hold;
   logic [31:0] dout;
   logic [1:0]  page;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_ack;

   localparam logic [31:0] T_DAT  = 32'h1234_5678;
   localparam logic [31:0] D_DAT  = 32'h2024_0615;
   localparam logic [31:0] P_DAT0 = 32'hFF23_5FCF;
   localparam logic [31:0] P_DAT1 = 32'hFF21_5FCF;
   localparam logic [31:0] M_DAT0 = 32'hFFFF_E88F;
   localparam logic [31:0] M_DAT1 = 32'hABCD_0123;
   localparam logic [31:0] M_DAT2 = 32'h5555_AAAA;

   disp_sched #(
      .CLK_HZ     (10),
      .PAGE_SEC   (2),
      .MSG_SEC    (1),
      .BLINK_HALF (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .time_dat   (time_dat),
      .date_dat   (date_dat),
      .temp_dat   (temp_dat),
      .temp_vld   (temp_vld),
      .msg_req    (msg_req),
      .msg_dat    (msg_dat),
      .msg_ack    (msg_ack),
      .blink_mask (blink_mask),
      .hold       (hold),
      .dout       (dout),
      .page       (page)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since the last reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to #1 after the n-th edge since reset release
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      time_dat   = T_DAT;
      date_dat   = D_DAT;
      temp_dat   = P_DAT0;
      temp_vld   = 1'b1;
      msg_req    = 1'b0;
      msg_dat    = 32'h0;
      blink_mask = 8'h00;
      hold       = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_dout", dout, 32'hFFFF_FFFF);
      chk("rst_page", 32'(page), 32'd0);
      chk("rst_ack", 32'(msg_ack), 32'd0);
      rst_n = 1'b1;

      // Rotation TIME -> DATE -> TEMP -> TIME, 20 cycles each
      goto(1);  chk("rot_time_first", 32'(page), 32'd0); chk("rot_time_dout", dout, T_DAT);
      goto(19); chk("rot_time_last", 32'(page), 32'd0);
      goto(20); chk("rot_date_first", 32'(page), 32'd1); chk("rot_date_dout", dout, D_DAT);
      goto(39); chk("rot_date_last", 32'(page), 32'd1);
      goto(40); chk("rot_temp_first", 32'(page), 32'd2); chk("rot_temp_dout", dout, P_DAT0);
      temp_dat = P_DAT1;
      goto(41); chk("src_latency", dout, P_DAT1);
      goto(59); chk("rot_temp_last", 32'(page), 32'd2);
      goto(60); chk("rot_back_time", 32'(page), 32'd0);

      // Temperature invalid: DATE goes straight back to TIME
      temp_vld = 1'b0;
      goto(80);  chk("skip_date", 32'(page), 32'd1);
      goto(100); chk("skip_to_time", 32'(page), 32'd0);
      temp_vld = 1'b1;
      goto(140); chk("drop_temp_entry", 32'(page), 32'd2);
      goto(144); temp_vld = 1'b0;
      goto(145); chk("drop_to_time", 32'(page), 32'd0); chk("drop_dout", dout, T_DAT);
      goto(164); chk("drop_full_dwell", 32'(page), 32'd0);
      goto(165); chk("drop_then_date", 32'(page), 32'd1);

      // Message on the 8th cycle of DATE
      goto(172); msg_req = 1'b1; msg_dat = M_DAT0;
      goto(173); chk("msg_ack", 32'(msg_ack), 32'd1); chk("msg_ack_page", 32'(page), 32'd1);
      msg_req = 1'b0;
      goto(174); chk("msg_page", 32'(page), 32'd3); chk("msg_dout", dout, M_DAT0);
      chk("msg_ack_one", 32'(msg_ack), 32'd0);
      goto(183); chk("msg_last", 32'(page), 32'd3); chk("msg_last_dout", dout, M_DAT0);
      goto(184); chk("msg_ret_date", 32'(page), 32'd1); chk("msg_ret_dout", dout, D_DAT);
      goto(203); chk("msg_ret_dwell", 32'(page), 32'd1);
      goto(204); chk("msg_ret_next", 32'(page), 32'd0);

      // Request held through the whole message yields one ack
      goto(205); msg_req = 1'b1; msg_dat = M_DAT1;
      n_ack = 0;
      for (int e = 206; e <= 217; e++) begin
         goto(e);
         if (msg_ack) n_ack++;
         if (e == 216) msg_req = 1'b0;
      end
      chk("held_one_ack", 32'(n_ack), 32'd1);
      chk("held_ret_time", 32'(page), 32'd0);

      // Request in the expiry cycle of TIME beats the rotation
      goto(236); msg_req = 1'b1; msg_dat = M_DAT2;
      goto(237); chk("sim_ack", 32'(msg_ack), 32'd1); chk("sim_stay_time", 32'(page), 32'd0);
      msg_req = 1'b0;
      goto(238); chk("sim_msg", 32'(page), 32'd3); chk("sim_msg_dout", dout, M_DAT2);
      goto(248); chk("sim_ret_time", 32'(page), 32'd0); chk("sim_ret_dout", dout, T_DAT);

      // Hold on TIME with blinking of the two rightmost digits
      hold = 1'b1; blink_mask = 8'h03;
      for (int e = 249; e <= 272; e++) begin
         goto(e);
         chk("hold_page", 32'(page), 32'd0);
         chk("blink_dout", dout, ((((e - 1) / 3) % 2) == 1) ? 32'h1234_56FF : T_DAT);
      end

      // Reset during a message
      hold = 1'b0; blink_mask = 8'h00; msg_req = 1'b1; msg_dat = M_DAT0;
      goto(273); chk("rstmsg_ack", 32'(msg_ack), 32'd1);
      msg_req = 1'b0;
      goto(274); chk("rstmsg_page", 32'(page), 32'd3);
      goto(276);
      rst_n = 1'b0;
      #1;
      chk("rstmsg_dout", dout, 32'hFFFF_FFFF);
      chk("rstmsg_pg", 32'(page), 32'd0);
      chk("rstmsg_ack0", 32'(msg_ack), 32'd0);
      repeat (2) @(negedge clk);
      chk("rstmsg_hold_dout", dout, 32'hFFFF_FFFF);
      rst_n = 1'b1;
      goto(1); chk("post_rst_page", 32'(page), 32'd0); chk("post_rst_dout", dout, T_DAT);
      goto(3); chk("post_rst_ack", 32'(msg_ack), 32'd0); chk("post_rst_page3", 32'(page), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
